if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Instruction-fetch stage directly downstream of the program counter. Takes the current fetch address from the PC register and issues in-order requests to instruction memory. Holds PC and instruction pairs in a small in-order queue and presents them to decode with a valid/ready handshake. Drives the PC stall input and discards in-flight fetches on a redirect (taken branch or jump).

Parameters:
W, 32, address and instruction width
DEPTH, 4, queue entries; power of two, at least 2; bounds outstanding plus buffered fetches

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
pc_i  input  W  current fetch address from PC register
flush_i  input  1  redirect this cycle; same signal as the PC target-select
stall_o  output  1  to PC hazard input; high = PC holds
imem_req_o  output  1  fetch request valid
imem_addr_o  output  W  fetch address; always equals pc_i
imem_gnt_i  input  1  memory accepts request this cycle
imem_rvalid_i  input  1  response valid; responses are in order, 1 or more cycles after grant
imem_rdata_i  input  W  instruction word
id_valid_o  output  1  head entry valid to decode
id_ready_i  input  1  decode accepts head
id_pc_o  output  W  PC of head entry
id_instr_o  output  W  instruction of head entry

Behaviour:
- Queue storage: DEPTH entries, each holding {pc, instr, filled}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count has 0..DEPTH range. drop_cnt has 0..DEPTH range.
- Reset (async, rst_ni low): pointers = 0, count = 0, drop_cnt = 0, all filled = 0.
  - Outputs during and after reset: id_valid_o = 0, id_pc_o = 0, id_instr_o = 0, imem_req_o = 0 while in reset.
  - After release, first request addresses 0.
- pop = id_valid_o & id_ready_i.
- Request issue: imem_req_o = !flush_i & (count + drop_cnt - pop < DEPTH). Arithmetic is unsigned with one guard bit.
- Reserve: on imem_req_o & imem_gnt_i, write pc_i into the tail entry with filled = 0, advance write pointer, count +1.
- stall_o = !flush_i & !(imem_req_o & imem_gnt_i).
  - PC advances exactly once per granted request.
  - PC is never stalled in a flush cycle, so it loads the redirect target.
- Response, drop_cnt = 0: on imem_rvalid_i, write imem_rdata_i into the oldest unfilled entry and set filled = 1. A fill pointer tracks this entry.
- Response, drop_cnt > 0: the response is discarded and drop_cnt decrements by 1.
- Head and pop:
  - id_valid_o = !flush_i & (count > 0) & head.filled.
  - id_pc_o and id_instr_o are driven from the head entry (registered storage, zero combinational path from imem).
  - On pop: clear head filled, advance read pointer, count -1.
- Reserve and pop in the same cycle: count unchanged.
- Full queue with head valid: a pop frees one credit in the same cycle. Throughput is 1 instruction per cycle with 1-cycle memory latency and DEPTH >= 2.
- Flush (flush_i high), for the next state:
  - All entries invalidated; count = 0; pointers reset to equal values.
  - drop_cnt = (drop_cnt + number of reserved-but-unfilled entries) minus 1 if imem_rvalid_i is high in the flush cycle. The response arriving in the flush cycle belongs to pre-flush traffic and is discarded.
  - No request is issued in the flush cycle.
  - No pop in the flush cycle (id_valid_o forced 0); decode sees no handshake.
- Latency: request granted at cycle t, response at t+L, earliest id_valid_o at t+L+1.
- imem_rvalid_i with no reserved-unfilled entry and drop_cnt = 0 is a protocol error. The response is ignored and state is unchanged; the bench flags it.
- Reset asserted mid-operation: all state cleared immediately. Any later imem responses are protocol errors by definition (memory is reset alongside).

Test Plan:
- Reset release, imem_gnt_i = 1, 1-cycle latency, rdata = addr XOR 0xA5A5_0000, id_ready_i = 1.
  - Requests at 0, 4, 8, 12, ... on consecutive cycles.
  - id outputs (pc 0, instr 0xA5A5_0000), (4, 0xA5A5_0004), ... one per cycle from cycle 2.
  - stall_o low throughout.
- id_ready_i = 0, DEPTH = 4.
  - Exactly 4 requests (0, 4, 8, 12), then imem_req_o = 0 and stall_o = 1; pc_i is held at 16.
  - Raising id_ready_i pops pc 0 and issues a request for 16 in the same cycle.
- imem_gnt_i low for 3 cycles at pc 8: stall_o high 3 cycles, pc_i held at 8, no duplicate entry; decode order is 0, 4, 8, 12.
- 3-cycle memory latency, two requests outstanding (0x20, 0x24), flush_i pulse with pc_i redirected to 0x100.
  - The next two responses are dropped.
  - The first id_valid_o carries pc 0x100.
- flush_i in the same cycle as imem_rvalid_i and id_valid_o & id_ready_i: the response is discarded, no pop occurs, and the queue is empty next cycle.
- rst_ni asserted for 1 cycle while the queue is full and 2 fetches are outstanding: all outputs return to 0 asynchronously, and the first post-reset request addresses 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// ============================================================================
// if_fetch_queue: in-order instruction fetch queue between PC and decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] pc_i,
    input  logic         flush_i,
    output logic         stall_o,
    output logic         imem_req_o,
    output logic [W-1:0] imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [W-1:0] imem_rdata_i,
    output logic         id_valid_o,
    input  logic         id_ready_i,
    output logic [W-1:0] id_pc_o,
    output logic [W-1:0] id_instr_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    logic [W-1:0]       pc_q    [DEPTH];
    logic [W-1:0]       pc_d    [DEPTH];
    logic [W-1:0]       instr_q [DEPTH];
    logic [W-1:0]       instr_d [DEPTH];
    logic [DEPTH-1:0]   filled_q, filled_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] fill_ptr_q, fill_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [c_cnt_w-1:0] pend_q, pend_d;
    logic [c_cnt_w-1:0] drop_q, drop_d;

    logic               w_pop;
    logic               w_res;
    logic               w_fill;
    logic               w_drop;
    logic [c_cnt_w:0]   w_credit;
    logic [c_cnt_w-1:0] w_flush_sum;

    assign id_valid_o  = !flush_i && (count_q != '0) && filled_q[rd_ptr_q];
    assign id_pc_o     = pc_q[rd_ptr_q];
    assign id_instr_o  = instr_q[rd_ptr_q];
    assign w_pop       = id_valid_o & id_ready_i;

    // Outstanding requests still owed a response count against capacity too.
    assign w_credit    = {1'b0, count_q} + {1'b0, drop_q} - {{c_cnt_w{1'b0}}, w_pop};
    assign imem_req_o  = rst_ni && !flush_i && (w_credit < c_depth);
    assign imem_addr_o = pc_i;
    assign w_res       = imem_req_o & imem_gnt_i;
    assign stall_o     = !flush_i && !w_res;

    assign w_fill      = imem_rvalid_i && (drop_q == '0) && (pend_q != '0);
    assign w_drop      = imem_rvalid_i && (drop_q != '0);
    assign w_flush_sum = drop_q + pend_q;

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        filled_d   = filled_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        count_d    = count_q;
        pend_d     = pend_q;
        drop_d     = drop_q;

        if (flush_i) begin
            filled_d   = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            count_d    = '0;
            pend_d     = '0;
            // A response landing during the flush belongs to old traffic.
            if (imem_rvalid_i && (w_flush_sum != '0)) begin
                drop_d = w_flush_sum - c_cnt_w'(1);
            end else begin
                drop_d = w_flush_sum;
            end
        end else begin
            if (w_pop) begin
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + c_ptr_w'(1);
            end
            if (w_res) begin
                pc_d[wr_ptr_q]     = pc_i;
                filled_d[wr_ptr_q] = 1'b0;
                wr_ptr_d           = wr_ptr_q + c_ptr_w'(1);
            end
            if (w_fill) begin
                instr_d[fill_ptr_q]  = imem_rdata_i;
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + c_ptr_w'(1);
            end
            if (w_drop) begin
                drop_d = drop_q - c_cnt_w'(1);
            end
            count_d = count_q + c_cnt_w'(w_res) - c_cnt_w'(w_pop);
            pend_d  = pend_q + c_cnt_w'(w_res) - c_cnt_w'(w_fill);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            filled_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            filled_q   <= filled_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// ============================================================================
// tb_if_fetch_queue: directed self-checking bench for if_fetch_queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;

    if_fetch_queue #(.W(32), .DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_pc_o      (id_pc_o),
        .id_instr_o   (id_instr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        int          due;
    } rsp_t;

    localparam logic [31:0] c_key = 32'hA5A5_0000;

    rsp_t        mq[$];
    logic [31:0] pc_m;
    logic [31:0] flush_tgt;
    int          lat;
    int          cyc;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs: PC register value plus the memory model.
    task automatic drive(input logic gnt, input logic rdy, input logic fl, input logic [31:0] tgt);
        pc_i       = pc_m;
        imem_gnt_i = gnt;
        id_ready_i = rdy;
        flush_i    = fl;
        flush_tgt  = tgt;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mq[0].a ^ c_key;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        #1;
    endtask

    task automatic step();
        logic g, s, rv;
        g  = imem_req_o & imem_gnt_i;
        s  = stall_o;
        rv = imem_rvalid_i;
        @(posedge clk_i);
        #1;
        if (rv) void'(mq.pop_front());
        if (g) mq.push_back('{a: pc_i, due: cyc + lat});
        if (flush_i) pc_m = flush_tgt;
        else if (!s) pc_m = pc_m + 32'd4;
        cyc++;
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        mq.delete();
        pc_m          = '0;
        pc_i          = '0;
        flush_i       = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        pc_m   = '0;
        lat    = 1;
        cyc    = 0;
        drive(1'b1, 1'b1, 1'b0, '0);
        #1;
        chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
        chk("rst_pc", id_pc_o, 32'd0);
        chk("rst_instr", id_instr_o, 32'd0);
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);

        // Streaming, 1-cycle latency, decode always ready
        do_reset();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t1_req0", {31'b0, imem_req_o}, 32'd1);
        chk("t1_addr0", imem_addr_o, 32'd0);
        chk("t1_valid0", {31'b0, id_valid_o}, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t1_addr1", imem_addr_o, 32'd4);
        chk("t1_valid1", {31'b0, id_valid_o}, 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            chk("t1_valid", {31'b0, id_valid_o}, 32'd1);
            chk("t1_pc", id_pc_o, 32'(4 * k));
            chk("t1_instr", id_instr_o, 32'(4 * k) ^ c_key);
            chk("t1_stall", {31'b0, stall_o}, 32'd0);
            chk("t1_addr", imem_addr_o, 32'(4 * k + 8));
            step();
        end

        // Decode not ready: queue fills after four requests
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            chk("t2_req", {31'b0, imem_req_o}, 32'd1);
            chk("t2_addr", imem_addr_o, 32'(4 * k));
            step();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            chk("t2_full_req", {31'b0, imem_req_o}, 32'd0);
            chk("t2_full_stall", {31'b0, stall_o}, 32'd1);
            chk("t2_hold_pc", pc_i, 32'd16);
            chk("t2_head", id_pc_o, 32'd0);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t2_pop_valid", {31'b0, id_valid_o}, 32'd1);
        chk("t2_pop_pc", id_pc_o, 32'd0);
        chk("t2_pop_req", {31'b0, imem_req_o}, 32'd1);
        chk("t2_pop_addr", imem_addr_o, 32'd16);
        chk("t2_pop_stall", {31'b0, stall_o}, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t2_next_pc", id_pc_o, 32'd4);
        step();

        // Grant withheld for three cycles at pc 8
        do_reset();
        drive(1'b1, 1'b1, 1'b0, '0); step();
        drive(1'b1, 1'b1, 1'b0, '0); step();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("t3_stall_a", {31'b0, stall_o}, 32'd1);
        chk("t3_pc_a", pc_i, 32'd8);
        chk("t3_id_a", id_pc_o, 32'd0);
        step();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("t3_stall_b", {31'b0, stall_o}, 32'd1);
        chk("t3_pc_b", pc_i, 32'd8);
        chk("t3_id_b", id_pc_o, 32'd4);
        step();
        drive(1'b0, 1'b1, 1'b0, '0);
        chk("t3_stall_c", {31'b0, stall_o}, 32'd1);
        chk("t3_pc_c", pc_i, 32'd8);
        chk("t3_empty", {31'b0, id_valid_o}, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t3_resume", {31'b0, stall_o}, 32'd0);
        chk("t3_addr", imem_addr_o, 32'd8);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t3_gap", {31'b0, id_valid_o}, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t3_id_8", id_pc_o, 32'd8);
        chk("t3_v8", {31'b0, id_valid_o}, 32'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t3_id_12", id_pc_o, 32'd12);
        step();

        // 3-cycle latency, redirect with two fetches outstanding
        do_reset();
        lat  = 3;
        pc_m = 32'h20;
        drive(1'b1, 1'b1, 1'b0, '0); step();
        drive(1'b1, 1'b1, 1'b0, '0); step();
        drive(1'b1, 1'b1, 1'b1, 32'h100);
        chk("t4_fl_req", {31'b0, imem_req_o}, 32'd0);
        chk("t4_fl_stall", {31'b0, stall_o}, 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            chk("t4_dropped", {31'b0, id_valid_o}, 32'd0);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t4_valid", {31'b0, id_valid_o}, 32'd1);
        chk("t4_pc", id_pc_o, 32'h100);
        chk("t4_instr", id_instr_o, 32'hA5A5_0100);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t4_pc2", id_pc_o, 32'h104);
        step();

        // Flush coinciding with a response and a would-be pop
        do_reset();
        lat = 1;
        drive(1'b1, 1'b1, 1'b0, '0); step();
        drive(1'b1, 1'b1, 1'b0, '0); step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t5_pre_pc", id_pc_o, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h200);
        chk("t5_fl_valid", {31'b0, id_valid_o}, 32'd0);
        chk("t5_fl_req", {31'b0, imem_req_o}, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t5_empty", {31'b0, id_valid_o}, 32'd0);
        chk("t5_req", {31'b0, imem_req_o}, 32'd1);
        chk("t5_addr", imem_addr_o, 32'h200);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t5_wait", {31'b0, id_valid_o}, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t5_valid", {31'b0, id_valid_o}, 32'd1);
        chk("t5_pc", id_pc_o, 32'h200);
        chk("t5_instr", id_instr_o, 32'hA5A5_0200);
        step();

        // Reset while full with two fetches in flight
        do_reset();
        lat = 2;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            step();
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        chk("t6_full_req", {31'b0, imem_req_o}, 32'd0);
        chk("t6_head", {31'b0, id_valid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, id_valid_o}, 32'd0);
        chk("t6_rst_pc", id_pc_o, 32'd0);
        chk("t6_rst_instr", id_instr_o, 32'd0);
        chk("t6_rst_req", {31'b0, imem_req_o}, 32'd0);
        do_reset();
        lat = 1;
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t6_post_req", {31'b0, imem_req_o}, 32'd1);
        chk("t6_post_addr", imem_addr_o, 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, '0); step();
        drive(1'b1, 1'b1, 1'b0, '0);
        chk("t6_post_pc", id_pc_o, 32'd0);
        chk("t6_post_instr", id_instr_o, 32'hA5A5_0000);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
